wb_gpio_irq_ctrl: RTL and testbench



---
 rtl/wb_gpio_irq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_wb_gpio_irq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_irq_ctrl.sv
// wb_gpio_irq_ctrl
//   Wishbone-slave GPIO controller with rising-edge interrupt capture.
//   Drives the pad outputs and active-low output enables from registers. It
//   samples the pad inputs through a 2-flop synchroniser plus one delay flop,
//   latches rising edges into a pending register and folds
//   (pending & enable) onto three interrupt lines (channel i -> line i mod 3).
//
// Ports
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      : Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]            : byte lane selects
//   wbs_adr_i[31:0]           : byte address
//   wbs_dat_i[31:0]           : write data
//   wbs_dat_o[31:0]           : read data (zero outside the ack cycle)
//   wbs_ack_o                 : single-cycle acknowledge
//   io_in[NUM_IO-1:0]         : asynchronous pad inputs
//   io_out[NUM_IO-1:0]        : pad output values
//   io_oeb[NUM_IO-1:0]        : pad output enables, active low
//   user_irq[2:0]             : interrupt lines
module wb_gpio_irq_ctrl #(
  parameter int          NUM_IO    = 38,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int          ACK_DELAY = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        user_irq
);

  // Channels are held in 64-bit registers; bits at or above NUM_IO are
  // forced to zero on every write so they read 0 and fold away as constants.
  localparam logic [63:0] IO_MASK    = (NUM_IO >= 64) ? {64{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);
  localparam logic [2:0]  DELAY_INIT = 3'(ACK_DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_DONE} state_t;

  function automatic logic [63:0] f_lane_mask(input int k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i % 3) == k) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] dat,
                                          input logic [31:0] bm);
    return (old_v & ~bm) | (dat & bm);
  endfunction

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [63:0] r_out, r_oeb, r_ien, r_pend;
  logic [63:0] r_s1, r_s2, r_s3, r_rise;
  logic        r_err;
  logic [2:0]  r_irq;
  logic [31:0] r_dat;

  logic        w_live, w_hit, w_ack_cycle, w_wr;
  logic [5:0]  w_word;
  logic [31:0] w_bmask, w_rd_data;
  logic [63:0] w_in_pad, w_pend_clr, w_active;
  logic        w_err_set, w_err_clr;
  logic [2:0]  w_irq;

  genvar gi;

  generate
    for (gi = 0; gi < 64; gi++) begin : g_in_pad
      if (gi < NUM_IO) begin : g_real
        assign w_in_pad[gi] = io_in[gi];
      end else begin : g_none
        assign w_in_pad[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_bmask
      assign w_bmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
    for (gi = 0; gi < 3; gi++) begin : g_irq
      assign w_irq[gi] = |(w_active & f_lane_mask(gi));
    end
  endgenerate

  assign w_live      = wbs_cyc_i & wbs_stb_i;
  assign w_hit       = w_live & ((wbs_adr_i & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign w_ack_cycle = (r_state == ST_ACK);
  assign w_wr        = w_ack_cycle & wbs_we_i;
  assign w_word      = wbs_adr_i[7:2];
  assign w_active    = r_pend & r_ien;

  // Offsets past STATUS are acked like any other access but flag ERR.
  assign w_err_set = w_ack_cycle & (w_word > 6'd10);
  assign w_err_clr = w_wr & (w_word == 6'd10) & wbs_sel_i[0] & wbs_dat_i[0];

  always_comb begin
    w_pend_clr = '0;
    if (w_wr && (w_word == 6'd8)) w_pend_clr[31:0]  = wbs_dat_i & w_bmask;
    if (w_wr && (w_word == 6'd9)) w_pend_clr[63:32] = wbs_dat_i & w_bmask;
  end

  always_comb begin
    w_rd_data = '0;
    case (w_word)
      6'd0:    w_rd_data = r_out[31:0];
      6'd1:    w_rd_data = r_out[63:32];
      6'd2:    w_rd_data = r_oeb[31:0];
      6'd3:    w_rd_data = r_oeb[63:32];
      6'd4:    w_rd_data = r_s2[31:0];
      6'd5:    w_rd_data = r_s2[63:32];
      6'd6:    w_rd_data = r_ien[31:0];
      6'd7:    w_rd_data = r_ien[63:32];
      6'd8:    w_rd_data = r_pend[31:0];
      6'd9:    w_rd_data = r_pend[63:32];
      6'd10:   w_rd_data = {28'd0, r_irq, r_err};
      default: w_rd_data = '0;
    endcase
  end

  // Bus handshake: count wait states, ack for one cycle, then insist the
  // master drops the strobe before a new request is accepted.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          if (ACK_DELAY == 0) begin
            w_state_next = ST_ACK;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = DELAY_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_live) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_next = ST_ACK;
        end
      end
      ST_ACK:  w_state_next = ST_DONE;
      ST_DONE: if (!w_live) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_out  <= '0;
      r_oeb  <= IO_MASK;
      r_ien  <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
      r_irq  <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_rise <= '0;
      r_dat  <= '0;
    end else begin
      r_s1   <= w_in_pad;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      // A fresh edge outranks a software clear landing on the same edge.
      r_pend <= (r_pend & ~w_pend_clr) | r_rise;
      r_err  <= (r_err & ~w_err_clr) | w_err_set;
      r_irq  <= w_irq;
      // Read data is captured as the FSM enters ACK and is zero otherwise.
      r_dat  <= (w_state_next == ST_ACK) ? w_rd_data : 32'd0;
      if (w_wr) begin
        case (w_word)
          6'd0: r_out[31:0]  <= f_merge(r_out[31:0],  wbs_dat_i, w_bmask) & IO_MASK[31:0];
          6'd1: r_out[63:32] <= f_merge(r_out[63:32], wbs_dat_i, w_bmask) & IO_MASK[63:32];
          6'd2: r_oeb[31:0]  <= f_merge(r_oeb[31:0],  wbs_dat_i, w_bmask) & IO_MASK[31:0];
          6'd3: r_oeb[63:32] <= f_merge(r_oeb[63:32], wbs_dat_i, w_bmask) & IO_MASK[63:32];
          6'd6: r_ien[31:0]  <= f_merge(r_ien[31:0],  wbs_dat_i, w_bmask) & IO_MASK[31:0];
          6'd7: r_ien[63:32] <= f_merge(r_ien[63:32], wbs_dat_i, w_bmask) & IO_MASK[63:32];
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = w_ack_cycle;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out[NUM_IO-1:0];
  assign io_oeb    = r_oeb[NUM_IO-1:0];
  assign user_irq  = r_irq;

endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// Testbench for wb_gpio_irq_ctrl (NUM_IO=38, ACK_DELAY=2).
// A cycle-level reference model built from the register map and timing
// rules is compared against the DUT outputs on every falling edge, and
// directed sequences pin the model with hand-computed literals.
module tb_wb_gpio_irq_ctrl;
  localparam int          NIO   = 38;
  localparam int          D     = 2;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [63:0] VALID = (64'd1 << NIO) - 64'd1;

  logic           clk = 1'b0;
  logic           rst, cyc, stb, we;
  logic [3:0]     sel;
  logic [31:0]    adr, wdat;
  logic [31:0]    dat_o;
  logic           ack;
  logic [NIO-1:0] io_in, io_out, io_oeb, io_dir;
  logic [2:0]     irq;
  logic           rand_io, chk_en;

  int total = 0;
  int bad   = 0;

  wb_gpio_irq_ctrl #(
    .NUM_IO(NIO), .ADDR_BASE(BASE), .ADDR_MASK(32'hFFFF_FF00), .ACK_DELAY(D)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_out, m_oeb, m_ien, m_pend;
  logic        m_err, m_ack, m_wait_low;
  logic [2:0]  m_irq;
  logic [31:0] m_dat;
  int          m_age;
  logic [63:0] m_h [4];  // m_h[j]: pads as sampled j+1 edges ago

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00: return m_out[31:0];
      8'h04: return m_out[63:32];
      8'h08: return m_oeb[31:0];
      8'h0C: return m_oeb[63:32];
      8'h10: return m_h[1][31:0];
      8'h14: return m_h[1][63:32];
      8'h18: return m_ien[31:0];
      8'h1C: return m_ien[63:32];
      8'h20: return m_pend[31:0];
      8'h24: return m_pend[63:32];
      8'h28: return {28'd0, m_irq, m_err};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] rise, clr, n_out, n_oeb, n_ien;
    logic [31:0] bm;
    logic [7:0]  off;
    logic [2:0]  nirq;
    logic        e_set, e_clr;
    int          age;
    if (rst) begin
      m_out <= '0; m_oeb <= VALID; m_ien <= '0; m_pend <= '0; m_err <= 1'b0;
      m_irq <= '0; m_ack <= 1'b0; m_dat <= '0; m_age <= 0; m_wait_low <= 1'b0;
      for (int j = 0; j < 4; j++) m_h[j] <= '0;
    end else begin
      rise = m_h[2] & ~m_h[3];
      m_h[0] <= 64'(io_in); m_h[1] <= m_h[0]; m_h[2] <= m_h[1]; m_h[3] <= m_h[2];
      nirq = '0;
      for (int i = 0; i < 64; i++) if (m_pend[i] && m_ien[i]) nirq[i % 3] = 1'b1;
      m_irq <= nirq;
      n_out = m_out; n_oeb = m_oeb; n_ien = m_ien; clr = '0; e_set = 1'b0; e_clr = 1'b0;
      off = {adr[7:2], 2'b00};
      bm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      if (m_ack) begin
        // the acked access takes effect on the edge that ends the ack cycle
        if (we) begin
          case (off)
            8'h00: n_out[31:0]  = (m_out[31:0]  & ~bm) | (wdat & bm);
            8'h04: n_out[63:32] = (m_out[63:32] & ~bm) | (wdat & bm);
            8'h08: n_oeb[31:0]  = (m_oeb[31:0]  & ~bm) | (wdat & bm);
            8'h0C: n_oeb[63:32] = (m_oeb[63:32] & ~bm) | (wdat & bm);
            8'h18: n_ien[31:0]  = (m_ien[31:0]  & ~bm) | (wdat & bm);
            8'h1C: n_ien[63:32] = (m_ien[63:32] & ~bm) | (wdat & bm);
            8'h20: clr[31:0]    = wdat & bm;
            8'h24: clr[63:32]   = wdat & bm;
            8'h28: e_clr        = sel[0] & wdat[0];
            default: ;
          endcase
        end
        e_set = (off > 8'h28);
        m_ack <= 1'b0; m_dat <= '0; m_wait_low <= 1'b1;
      end else if (m_wait_low) begin
        if (!(cyc && stb)) m_wait_low <= 1'b0;
      end else begin
        age = m_age;
        if (age > 0 && !(cyc && stb)) begin
          age = 0;
        end else if (age > 0 || (cyc && stb && adr[31:8] == BASE[31:8])) begin
          age++;
          if (age == D + 1) begin
            m_ack <= 1'b1;
            m_dat <= m_read(off);
            age = 0;
          end
        end
        m_age <= age;
      end
      m_out  <= n_out & VALID;
      m_oeb  <= n_oeb & VALID;
      m_ien  <= n_ien & VALID;
      m_pend <= (m_pend & ~clr) | rise;
      m_err  <= (m_err & ~e_clr) | e_set;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_io_out", 64'(io_out), m_out);
      chk("cyc_io_oeb", 64'(io_oeb), m_oeb);
      chk("cyc_user_irq", 64'(irq), 64'(m_irq));
      chk("cyc_ack", 64'(ack), 64'(m_ack));
      chk("cyc_dat_o", 64'(dat_o), 64'(m_dat));
    end
  end

  // ---------------- pad driver ----------------
  function automatic logic [NIO-1:0] rmask();
    logic [63:0] a;
    a = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    return a[NIO-1:0];
  endfunction

  initial begin
    io_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_io) io_in = io_in ^ rmask();
      else         io_in = io_dir;
    end
  end

  // ---------------- bus helpers ----------------
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int bound,
                    output logic [31:0] rd, output logic acked, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; lat = -1; rd = '0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1; lat = n; rd = dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    if (acked) begin
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    logic        ok;
    int          lat;
    logic [31:0] exp_rst [11];
    logic [7:0]  off;
    int          r;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    io_dir = '0; rand_io = 1'b0; chk_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    rst = 1'b0;

    // reset state
    chk("rst_io_oeb", 64'(io_oeb), 64'h0000_003F_FFFF_FFFF);
    chk("rst_io_out", 64'(io_out), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    for (int i = 0; i < 11; i++) exp_rst[i] = 32'd0;
    exp_rst[2] = 32'hFFFF_FFFF;
    exp_rst[3] = 32'h0000_003F;
    for (int i = 0; i < 11; i++) begin
      wb(1'b0, BASE + 32'(i * 4), 32'd0, 4'hF, 20, rd, ok, lat);
      chk($sformatf("rst_read_%02h", i * 4), 64'(rd), 64'(exp_rst[i]));
    end

    // byte-lane write with latency check
    wb(1'b1, BASE, 32'hA5A5_A5A5, 4'b0011, 20, rd, ok, lat);
    chk("out_lo_latency", 64'(lat), 64'd3);
    chk("out_lo_pins", 64'(io_out[31:0]), 64'h0000_A5A5);
    wb(1'b0, BASE, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("out_lo_read", 64'(rd), 64'h0000_A5A5);

    // only six OEB_HI bits exist
    wb(1'b1, BASE + 32'h0C, 32'hFFFF_FFC0, 4'hF, 20, rd, ok, lat);
    chk("oeb_hi_pins", 64'(io_oeb[37:32]), 64'd0);
    wb(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("oeb_hi_read", 64'(rd), 64'd0);

    // edge on channel 4 -> pending -> user_irq[1]
    wb(1'b1, BASE + 32'h18, 32'h0000_0010, 4'hF, 20, rd, ok, lat);
    io_dir[4] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("irq_before_t4", 64'(irq), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("irq_at_t4", 64'(irq), 64'b010);
    @(posedge clk); #1;
    wb(1'b0, BASE + 32'h20, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("pend_lo_read", 64'(rd), 64'h10);
    wb(1'b1, BASE + 32'h20, 32'h0000_0010, 4'hF, 20, rd, ok, lat);
    chk("irq_after_w1c", 64'(irq), 64'd0);

    // edge and W1C on the same edge: edge wins
    io_dir[4] = 1'b0;
    idle(6);
    io_dir[4] = 1'b1;
    wb(1'b1, BASE + 32'h20, 32'h0000_0010, 4'hF, 20, rd, ok, lat);
    wb(1'b0, BASE + 32'h20, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("pend_set_wins", 64'(rd), 64'h10);
    wb(1'b1, BASE + 32'h20, 32'h0000_0010, 4'hF, 20, rd, ok, lat);

    // unmapped offset inside the window
    wb(1'b0, BASE + 32'h40, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("unmapped_ack", 64'(ok), 64'd1);
    chk("unmapped_data", 64'(rd), 64'd0);
    wb(1'b0, BASE + 32'h28, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("status_err", 64'(rd), 64'h1);
    wb(1'b1, BASE + 32'h28, 32'h1, 4'hF, 20, rd, ok, lat);
    wb(1'b0, BASE + 32'h28, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("status_cleared", 64'(rd), 64'h0);

    // outside the window
    wb(1'b0, 32'h3000_0100, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("miss_no_ack", 64'(ok), 64'd0);

    // reset while waiting
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstwait_no_ack", 64'(ack), 64'd0);
    end
    chk("rstwait_io_out", 64'(io_out), 64'd0);
    @(posedge clk); #1;
    wb(1'b0, BASE, 32'd0, 4'hF, 20, rd, ok, lat);
    chk("rstwait_out_lo", 64'(rd), 64'd0);

    // randomized traffic with toggling pads
    rand_io = 1'b1;
    for (int t = 0; t < 400; t++) begin
      r   = $urandom_range(0, 15);
      off = 8'($urandom_range(0, 12) * 4);
      if (r == 0) begin
        cyc = 1'b1; stb = 1'b1; we = 1'($urandom); adr = BASE | 32'(off);
        sel = 4'($urandom); wdat = $urandom;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(1);
      end else if (r == 1) begin
        wb(1'($urandom), 32'h3000_0100 | ($urandom & 32'h0FFF_FFFC), $urandom, 4'hF, 6,
           rd, ok, lat);
        chk("rand_miss", 64'(ok), 64'd0);
      end else begin
        wb(1'($urandom), BASE | 32'(off), $urandom, 4'($urandom), 20, rd, ok, lat);
        chk("rand_latency", 64'(lat), 64'(D + 1));
      end
    end
    rand_io = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
